// File: rtl/delay_module.sv
`default_nettype none
// ============================================================================
//  Module      : delay_module
//  Description : Programmable periodic tick generator. Raises out_delay for
//                one clock cycle once every `delay` cycles. A period of zero
//                disables the strobe. A new period is accepted only at a
//                period boundary, or immediately while disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module delay_module #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] delay,
    output logic             out_delay
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    // Cycle position within the current period; never exceeds r_per - 1.
    logic [WIDTH-1:0] r_cnt;
    // Active period, latched from delay at reset, while disabled, or at the
    // terminal count.
    logic [WIDTH-1:0] r_per;
    // Registered strobe driving out_delay.
    logic             r_out;

    // Terminal-count value. Only used when r_per is non-zero, so the
    // wrap-around for r_per == 0 never matters.
    logic [WIDTH-1:0] w_last;
    logic             w_disabled;
    logic             w_terminal;

    // Decode the period state from the active period and current count.
    always_comb begin
        w_last     = r_per - c_ONE;
        w_disabled = (r_per == c_ZERO);
        w_terminal = (r_cnt == w_last);
    end

    // Period counter and strobe register, in priority order: reset,
    // disabled, terminal count, counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_ZERO;
            r_out <= 1'b0;
            r_per <= delay;
        end else if (w_disabled) begin
            // Re-sample delay every cycle so enabling starts a fresh period.
            r_cnt <= c_ZERO;
            r_out <= 1'b0;
            r_per <= delay;
        end else if (w_terminal) begin
            // End of period: strobe and accept the requested period.
            r_cnt <= c_ZERO;
            r_out <= 1'b1;
            r_per <= delay;
        end else begin
            r_cnt <= r_cnt + c_ONE;
            r_out <= 1'b0;
        end
    end

    assign out_delay = r_out;

endmodule
`default_nettype wire

// File: tb/tb_delay_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_module
//  Description : Scoreboard bench for delay_module. The driver applies one
//                input set per clock edge and pushes the expected strobe,
//                computed from an absolute-time model (edge index of the next
//                strobe), into a queue. A monitor pops and compares on every
//                falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_delay_module;

    localparam int WIDTH = 9;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] delay;
    logic             out_delay;

    delay_module #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .delay     (delay),
        .out_delay (out_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    bit    q_exp[$];
    string q_tag[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: absolute edge index, active period, and the edge
    // index at which the next strobe is due.
    int    t_edge   = 0;
    int    m_per    = 0;
    int    m_next   = 0;
    bit    last_exp = 1'b0;
    string phase    = "init";

    // Predict the strobe produced by the coming edge, push it, then advance.
    task automatic step(input bit r, input int d);
        bit e;
        rst   = r;
        delay = d[WIDTH-1:0];
        t_edge++;
        if (r || m_per == 0) begin
            m_per  = d % (1 << WIDTH);
            m_next = t_edge + m_per;
            e      = 1'b0;
        end else if (t_edge == m_next) begin
            e      = 1'b1;
            m_per  = d % (1 << WIDTH);
            m_next = t_edge + m_per;
        end else begin
            e      = 1'b0;
        end
        last_exp = e;
        q_exp.push_back(e);
        q_tag.push_back(phase);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int d);
        for (int i = 0; i < n; i++) step(1'b0, d);
    endtask

    // Monitor: the DUT presents a strobe value every cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            bit    e;
            string tg;
            e  = q_exp.pop_front();
            tg = q_tag.pop_front();
            total++;
            if (out_delay !== e) begin
                bad++;
                $display("FAIL %s edge-check: out_delay=%b expected=%b at t=%0t",
                         tg, out_delay, e, $time);
            end
        end
    end

    int unsigned v;
    int          guard;

    initial begin
        rst   = 1'b1;
        delay = '0;

        phase = "reset_hold";
        for (int i = 0; i < 3; i++) step(1'b1, 10);

        phase = "period10";
        run(55, 10);

        phase = "delay1";
        step(1'b1, 1);
        run(20, 1);

        phase = "delay0";
        step(1'b1, 0);
        run(100, 0);

        phase = "midchange";
        step(1'b1, 10);
        guard = 0;
        while (!last_exp && guard < 40) begin
            step(1'b0, 10);
            guard++;
        end
        run(3, 10);
        run(30, 4);

        phase = "trunc600";
        v = 600;
        step(1'b1, int'(v[WIDTH-1:0]));
        run(3 * 88 + 2, int'(v[WIDTH-1:0]));

        phase = "max511";
        step(1'b1, 511);
        run(3 * 511 + 2, 511);

        phase = "reset_mid";
        step(1'b1, 10);
        run(10 + 5, 10);
        step(1'b1, 10);
        run(25, 10);

        phase = "enable";
        run(20, 0);
        run(30, 6);

        phase = "random";
        for (int k = 0; k < 60; k++) begin
            int d;
            int n;
            d = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 20));
            n = $urandom_range(1, 25);
            if ($urandom_range(0, 9) == 0) step(1'b1, d);
            run(n, d);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: queued=%0d expected=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
